// File: rtl/header_fifo_ctrl_if.sv
// Bus bundle for the header FIFO controller: producer write ports, the raw FIFO
// ports and the consumer stream. slave is the controller's view; master is everything around it.
interface header_fifo_ctrl_if #(
    parameter int WIDTH = 115,
    parameter int LVL_W = 10
);
    logic [1:0]         src_valid;
    logic [2*WIDTH-1:0] src_data;
    logic [1:0]         src_ready;

    logic               fifo_we;
    logic [WIDTH-1:0]   fifo_di;
    logic               fifo_full;
    logic               fifo_re;
    logic [WIDTH-1:0]   fifo_do;
    logic               fifo_empty;
    logic               fifo_rst;

    logic               hdr_valid;
    logic [WIDTH-1:0]   hdr_data;
    logic               hdr_ready;
    logic [LVL_W-1:0]   hdr_level;

    modport slave (
        input  src_valid, src_data, fifo_full, fifo_do, fifo_empty, hdr_ready,
        output src_ready, fifo_we, fifo_di, fifo_re, fifo_rst, hdr_valid, hdr_data, hdr_level
    );

    modport master (
        output src_valid, src_data, fifo_full, fifo_do, fifo_empty, hdr_ready,
        input  src_ready, fifo_we, fifo_di, fifo_re, fifo_rst, hdr_valid, hdr_data, hdr_level
    );
endinterface

// File: rtl/header_fifo_ctrl.sv
// Header FIFO sequencer: round-robin write arbiter for two producers, a 2-entry skid
// buffer turning the 1-cycle-latency FIFO read port into a registered valid/ready stream, plus level tracking.
module header_fifo_ctrl #(
    parameter int WIDTH = 115,
    parameter int DEPTH = 512,
    parameter int LVL_W = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    header_fifo_ctrl_if.slave  bus
);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH + 2);

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    // ---------------- write arbiter ----------------
    logic       rr_q, rr_d;
    logic [1:0] gnt;
    logic       gnt_idx;
    logic       wr_en;

    always_comb begin
        gnt     = 2'b00;
        gnt_idx = rr_q;
        if (!(bus.fifo_full | rst_i | flush_i)) begin
            case (bus.src_valid)
                2'b01:   gnt_idx = 1'b0;
                2'b10:   gnt_idx = 1'b1;
                default: gnt_idx = rr_q;
            endcase
            if (|bus.src_valid) gnt[gnt_idx] = 1'b1;
        end
    end

    assign wr_en         = |(bus.src_valid & gnt);
    assign bus.src_ready = gnt;
    assign bus.fifo_we   = wr_en;
    assign bus.fifo_di   = !wr_en ? '0 :
                           gnt_idx ? bus.src_data[WIDTH +: WIDTH] : bus.src_data[0 +: WIDTH];
    assign rr_d          = wr_en ? ~gnt_idx : rr_q;

    // ---------------- read side ----------------
    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic             inflight_q;
    logic             pop, rd_en;
    logic [2:0]       occ;

    assign bus.hdr_valid = (state_q != BUF_EMPTY);
    assign bus.hdr_data  = head_q;
    assign pop           = bus.hdr_valid & bus.hdr_ready;

    // Words held or already requested after this cycle's pop; keep it below 2 so a capture always fits.
    assign occ           = 3'(state_q) + 3'(inflight_q) - 3'(pop);
    assign rd_en         = !bus.fifo_empty && !flush_i && !rst_i && (occ < 3'd2);
    assign bus.fifo_re   = rd_en;
    assign bus.fifo_rst  = rst_i | flush_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            BUF_EMPTY: begin
                if (inflight_q) begin
                    head_d  = bus.fifo_do;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                case ({inflight_q, pop})
                    2'b10: begin
                        tail_d  = bus.fifo_do;
                        state_d = BUF_TWO;
                    end
                    2'b11:   head_d  = bus.fifo_do;
                    2'b01:   state_d = BUF_EMPTY;
                    default: ;
                endcase
            end
            BUF_TWO: begin
                if (pop) begin
                    head_d = tail_q;
                    if (inflight_q) tail_d = bus.fifo_do;
                    else            state_d = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        if (flush_i) state_d = BUF_EMPTY;
    end

    // ---------------- level ----------------
    logic [LVL_W-1:0] lvl_q, lvl_d;

    always_comb begin
        lvl_d = lvl_q;
        case ({wr_en, pop})
            2'b10:   if (lvl_q != LVL_MAX) lvl_d = lvl_q + 1'b1;
            2'b01:   if (lvl_q != '0)      lvl_d = lvl_q - 1'b1;
            default: ;
        endcase
        if (flush_i) lvl_d = '0;
    end

    assign bus.hdr_level = lvl_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= 1'b0;
            state_q    <= BUF_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            inflight_q <= 1'b0;
            lvl_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= rd_en;
            lvl_q      <= lvl_d;
            // Reaching either level limit means the count no longer matches reality.
            if (!flush_i) begin
                assert (!(wr_en && !pop && lvl_q == LVL_MAX));
                assert (!(pop && !wr_en && lvl_q == '0));
            end
        end
    end
endmodule

// File: tb/tb_header_fifo_ctrl.sv
// Directed bench for header_fifo_ctrl with a behavioural 1-cycle-latency FIFO model.
module tb_header_fifo_ctrl;
    localparam int W  = 115;
    localparam int D  = 512;
    localparam int LW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    header_fifo_ctrl_if #(.WIDTH(W), .LVL_W(LW)) bus ();

    header_fifo_ctrl #(.WIDTH(W), .DEPTH(D), .LVL_W(LW)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .flush_i(flush),
        .bus    (bus)
    );

    // FIFO model
    logic [W-1:0] mem[$];
    int           fcnt = 0;
    logic         force_full = 1'b0;
    assign bus.fifo_full  = force_full;
    assign bus.fifo_empty = (fcnt == 0);

    always @(posedge clk) begin
        if (bus.fifo_rst) begin
            mem.delete();
            fcnt <= 0;
        end else begin
            if (bus.fifo_re && mem.size() > 0) bus.fifo_do <= mem.pop_front();
            if (bus.fifo_we) mem.push_back(bus.fifo_di);
            fcnt <= mem.size();
        end
    end

    // Monitor: samples settled values half a cycle before each transfer edge
    int           cyc = 0;
    int           clr_req = 0, clr_seen = 0;
    int           n_re, first_re, first_v, run, maxrun, lvl_max;
    logic [W-1:0] plog[$];
    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(negedge clk);
        #2;
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            n_re = 0; first_re = -1; first_v = -1; run = 0; maxrun = 0; lvl_max = 0;
            plog.delete();
        end
        if (bus.fifo_re) begin
            n_re++;
            if (first_re < 0) first_re = cyc;
        end
        if (bus.hdr_valid && first_v < 0) first_v = cyc;
        if (bus.hdr_valid && bus.hdr_ready) begin
            plog.push_back(bus.hdr_data);
            run++;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
        if (int'(bus.hdr_level) > lvl_max) lvl_max = int'(bus.hdr_level);
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mkw(input logic [7:0] t, input int k);
        return {t, 92'h0, k[6:0], t};
    endfunction

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < 40 && plog.size() < n; i++) nxt();
        #1;
        chk(tag, plog.size(), n);
    endtask

    initial begin
        bus.src_valid = 2'b00;
        bus.src_data  = '0;
        bus.hdr_ready = 1'b0;

        // T1: reset with both producers requesting
        bus.src_valid = 2'b11;
        for (int i = 0; i < 2; i++) begin
            nxt(); #1;
            chk("rst_src_ready", bus.src_ready, 2'b00);
            chk("rst_fifo_rst", bus.fifo_rst, 1'b1);
            chk("rst_hdr_valid", bus.hdr_valid, 1'b0);
            chk("rst_level", bus.hdr_level, 0);
        end
        chk("rst_fifo_we", bus.fifo_we, 1'b0);
        chk("rst_fifo_re", bus.fifo_re, 1'b0);
        chk("rst_hdr_data", bus.hdr_data, 0);

        // T2: both producers, round robin A0,B0,A1,B1,A2,B2
        nxt();
        rst = 1'b0;
        clr_req++;
        bus.hdr_ready = 1'b1;
        begin
            int ai, bi;
            ai = 0; bi = 0;
            for (int k = 0; k < 6; k++) begin
                bus.src_valid = {logic'(bi < 3), logic'(ai < 3)};
                bus.src_data  = {mkw(8'hB0, bi), mkw(8'hA0, ai)};
                #1;
                chk("t2_src_ready", bus.src_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
                chk("t2_fifo_di", bus.fifo_di, (k % 2 == 0) ? mkw(8'hA0, k / 2) : mkw(8'hB0, k / 2));
                nxt();
                if (k % 2 == 0) ai++; else bi++;
            end
        end
        bus.src_valid = 2'b00;
        drain("t2_count", 6);
        for (int k = 0; k < 6 && k < plog.size(); k++)
            chk("t2_order", plog[k], (k % 2 == 0) ? mkw(8'hA0, k / 2) : mkw(8'hB0, k / 2));
        chk("t2_level_peak", lvl_max, 3);
        chk("t2_level_end", bus.hdr_level, 0);
        chk("t2_valid_end", bus.hdr_valid, 1'b0);

        // T3: 8 words streamed from producer 1, consumer always ready
        nxt();
        clr_req++;
        for (int k = 0; k < 8; k++) begin
            bus.src_valid = 2'b10;
            bus.src_data  = {mkw(8'hC0, k), mkw(8'h00, 0)};
            #1;
            chk("t3_src_ready", bus.src_ready, 2'b10);
            nxt();
        end
        bus.src_valid = 2'b00;
        drain("t3_count", 8);
        for (int k = 0; k < 8 && k < plog.size(); k++)
            chk("t3_order", plog[k], mkw(8'hC0, k));
        chk("t3_latency", first_v - first_re, 2);
        chk("t3_back_to_back", maxrun, 8);

        // T4: consumer stalled while 5 words arrive
        nxt();
        clr_req++;
        bus.hdr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.src_valid = 2'b01;
            bus.src_data  = {mkw(8'h00, 0), mkw(8'hD0, k)};
            nxt();
        end
        bus.src_valid = 2'b00;
        repeat (4) nxt();
        #1;
        chk("t4_reads_issued", n_re, 2);
        chk("t4_hdr_valid", bus.hdr_valid, 1'b1);
        chk("t4_hdr_data_held", bus.hdr_data, mkw(8'hD0, 0));
        chk("t4_level", bus.hdr_level, 5);
        nxt();
        clr_req++;
        bus.hdr_ready = 1'b1;
        drain("t4_count", 5);
        for (int k = 0; k < 5 && k < plog.size(); k++)
            chk("t4_order", plog[k], mkw(8'hD0, k));
        chk("t4_back_to_back", maxrun, 5);

        // T5: FIFO full blocks both producers; rr pointer (now 1) picks producer 1 afterwards
        nxt();
        clr_req++;
        force_full    = 1'b1;
        bus.src_valid = 2'b11;
        bus.src_data  = {mkw(8'hF0, 0), mkw(8'hE0, 0)};
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t5_full_ready", bus.src_ready, 2'b00);
            chk("t5_full_we", bus.fifo_we, 1'b0);
            nxt();
        end
        force_full = 1'b0;
        #1;
        chk("t5_rr_grant", bus.src_ready, 2'b10);
        chk("t5_rr_di", bus.fifo_di, mkw(8'hF0, 0));
        nxt(); #1;
        chk("t5_rr_next", bus.src_ready, 2'b01);
        chk("t5_rr_next_di", bus.fifo_di, mkw(8'hE0, 0));
        nxt();
        bus.src_valid = 2'b00;
        drain("t5_count", 2);
        if (plog.size() >= 2) begin
            chk("t5_order0", plog[0], mkw(8'hF0, 0));
            chk("t5_order1", plog[1], mkw(8'hE0, 0));
        end

        // T6: flush with a buffered word, a read in flight and a concurrent write
        nxt();
        clr_req++;
        bus.hdr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.src_valid = 2'b01;
            bus.src_data  = {mkw(8'h00, 0), mkw(8'h60, k)};
            nxt();
        end
        flush         = 1'b1;
        bus.hdr_ready = 1'b1;
        bus.src_data  = {mkw(8'h00, 0), mkw(8'h99, 0)};
        #1;
        chk("t6_fifo_rst", bus.fifo_rst, 1'b1);
        chk("t6_src_ready", bus.src_ready, 2'b00);
        chk("t6_fifo_we", bus.fifo_we, 1'b0);
        chk("t6_fifo_re", bus.fifo_re, 1'b0);
        chk("t6_hdr_valid_pre", bus.hdr_valid, 1'b1);
        chk("t6_hdr_data_pre", bus.hdr_data, mkw(8'h60, 0));
        nxt();
        flush         = 1'b0;
        bus.src_valid = 2'b00;
        #1;
        chk("t6_fifo_rst_end", bus.fifo_rst, 1'b0);
        chk("t6_hdr_valid_post", bus.hdr_valid, 1'b0);
        chk("t6_level_post", bus.hdr_level, 0);
        nxt(); #1;
        chk("t6_inflight_dropped", bus.hdr_valid, 1'b0);
        bus.src_valid = 2'b01;
        bus.src_data  = {mkw(8'h00, 0), mkw(8'h77, 0)};
        #1;
        chk("t6_fresh_ready", bus.src_ready, 2'b01);
        nxt();
        bus.src_valid = 2'b00;
        drain("t6_count", 2);
        if (plog.size() >= 2) begin
            chk("t6_order0", plog[0], mkw(8'h60, 0));
            chk("t6_order1", plog[1], mkw(8'h77, 0));
        end
        chk("t6_level_end", bus.hdr_level, 0);

        nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
